// File: rtl/saturn_ctrl_unit.sv
// saturn_ctrl_unit: Saturn control unit. It queues bus command/data nibbles
// into a program buffer, fetches and decodes instruction nibbles, owns
// PC/P/ST/HST/C and exposes state to the debugger.
// Optional feature: define SATURN_CTRL_GOTO_EN to decode the relative GOTO (6 x0 x1 x2).
module saturn_ctrl_unit #(
    parameter int unsigned PROG_DEPTH = 32,
    parameter logic [19:0] RESET_PC   = 20'h00000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clk_en,
    input  logic [3:0]  i_phases,
    input  logic [1:0]  i_phase,
    input  logic [31:0] i_cycle_ctr,
    input  logic        i_bus_busy,
    output logic [4:0]  o_program_address,
    input  logic [4:0]  i_program_address,
    output logic [4:0]  o_program_data,
    output logic        o_no_read,
    input  logic [3:0]  i_nibble,
    output logic        o_error,
    output logic [19:0] o_current_pc,
    output logic [3:0]  o_reg_hst,
    output logic [15:0] o_reg_st,
    output logic [3:0]  o_reg_p,
    input  logic [4:0]  i_dbg_register,
    input  logic [3:0]  i_dbg_reg_ptr,
    output logic [3:0]  o_dbg_reg_nibble,
    output logic [4:0]  o_alu_reg_dest,
    output logic [4:0]  o_alu_reg_src_1,
    output logic [4:0]  o_alu_reg_src_2,
    output logic [3:0]  o_alu_imm_value,
    output logic [4:0]  o_alu_opcode,
    output logic [3:0]  o_instr_type,
    output logic        o_instr_decoded
);
    localparam logic [4:0] ALU_NONE  = 5'h1F;
    localparam logic [2:0] LOAD_LAST = 3'd6;
    localparam logic [3:0] TYPE_LC   = 4'd2;

    typedef enum logic [1:0] {S_LOAD, S_FETCH, S_HALT} state_t;
    typedef enum logic [3:0] {D_START, D_P, D_LC_N, D_LC_D, D_ST0, D_8,
                              D_HST, D_STC, D_STS, D_G0, D_G1, D_G2} dec_t;

    state_t      state, state_n;
    dec_t        dec, dec_n;
    logic [4:0]  wr_ptr, wr_ptr_n;
    logic [2:0]  load_cnt, load_cnt_n;
    logic [19:0] pc, pc_n, g_base, g_base_n, target;
    logic [3:0]  p, p_n, hst, hst_n, lc_ptr, lc_ptr_n, lc_left, lc_left_n;
    logic [15:0] st, st_n;
    logic [63:0] c, c_n;
    logic [7:0]  g_lo, g_lo_n;
    logic        err, err_n, no_read, no_read_n, decoded, decoded_n;
    logic [3:0]  itype, itype_n, alu_imm, alu_imm_n, fin_type;
    logic [4:0]  alu_dest, alu_dest_n, alu_src1, alu_src1_n, alu_src2, alu_src2_n;
    logic [4:0]  alu_op, alu_op_n;
    logic        consume, fin, fault, buf_we;
    logic [4:0]  buf_wdata;
    logic [4:0]  prog_buf [PROG_DEPTH];
    logic        unused_trace;

    assign unused_trace = ^{i_phase, i_cycle_ctr};

    // Next state, buffer write and decode of the consumed nibble
    always_comb begin
        state_n    = state;
        dec_n      = dec;
        wr_ptr_n   = wr_ptr;
        load_cnt_n = load_cnt;
        pc_n       = pc;
        p_n        = p;
        st_n       = st;
        hst_n      = hst;
        c_n        = c;
        err_n      = err;
        no_read_n  = no_read;
        decoded_n  = 1'b0;
        itype_n    = itype;
        alu_dest_n = alu_dest;
        alu_src1_n = alu_src1;
        alu_src2_n = alu_src2;
        alu_imm_n  = alu_imm;
        alu_op_n   = alu_op;
        lc_ptr_n   = lc_ptr;
        lc_left_n  = lc_left;
        g_base_n   = g_base;
        g_lo_n     = g_lo;
        buf_we     = 1'b0;
        fin        = 1'b0;
        fin_type   = 4'd0;
        fault      = 1'b0;
        target     = g_base + {{8{i_nibble[3]}}, i_nibble, g_lo};
        consume    = i_clk_en && (state == S_FETCH) && (i_phases == 4'b0100) && !i_bus_busy;

        buf_wdata = 5'h12;
        case (load_cnt)
            3'd0:    buf_wdata = 5'h16;
            3'd1:    buf_wdata = {1'b0, pc[3:0]};
            3'd2:    buf_wdata = {1'b0, pc[7:4]};
            3'd3:    buf_wdata = {1'b0, pc[11:8]};
            3'd4:    buf_wdata = {1'b0, pc[15:12]};
            3'd5:    buf_wdata = {1'b0, pc[19:16]};
            default: buf_wdata = 5'h12;
        endcase

        if (i_clk_en && (state == S_LOAD)) begin
            buf_we   = 1'b1;
            wr_ptr_n = wr_ptr + 5'd1;
            if (load_cnt == LOAD_LAST) begin
                load_cnt_n = 3'd0;
                state_n    = S_FETCH;
                no_read_n  = 1'b0;
            end else begin
                load_cnt_n = load_cnt + 3'd1;
            end
        end

        if (consume) begin
            pc_n = pc + 20'd1;
            unique case (dec)
                D_START: begin
                    case (i_nibble)
                        4'h2:    dec_n = D_P;
                        4'h3:    dec_n = D_LC_N;
                        4'h0:    dec_n = D_ST0;
                        4'h8:    dec_n = D_8;
`ifdef SATURN_CTRL_GOTO_EN
                        4'h6:    dec_n = D_G0;
`endif
                        default: fault = 1'b1;
                    endcase
                end
                D_P: begin
                    p_n = i_nibble; fin = 1'b1; fin_type = 4'd1;
                end
                D_LC_N: begin
                    lc_left_n = i_nibble; lc_ptr_n = p; dec_n = D_LC_D;
                end
                D_LC_D: begin
                    c_n[{lc_ptr, 2'b00} +: 4] = i_nibble;
                    lc_ptr_n   = lc_ptr + 4'd1;
                    alu_dest_n = 5'd2;
                    alu_op_n   = 5'd1;
                    alu_imm_n  = i_nibble;
                    alu_src1_n = ALU_NONE;
                    alu_src2_n = ALU_NONE;
                    if (lc_left == 4'd0) begin
                        fin = 1'b1; fin_type = TYPE_LC;
                    end else begin
                        lc_left_n = lc_left - 4'd1;
                    end
                end
                D_ST0: begin
                    if (i_nibble == 4'h8) begin
                        st_n[11:0] = 12'h000; fin = 1'b1; fin_type = 4'd3;
                    end else begin
                        fault = 1'b1;
                    end
                end
                D_8: begin
                    case (i_nibble)
                        4'h2:    dec_n = D_HST;
                        4'h4:    dec_n = D_STC;
                        4'h5:    dec_n = D_STS;
                        default: fault = 1'b1;
                    endcase
                end
                D_HST: begin
                    hst_n = hst & ~i_nibble; fin = 1'b1; fin_type = 4'd4;
                end
                D_STC: begin
                    st_n[i_nibble] = 1'b0; fin = 1'b1; fin_type = 4'd5;
                end
                D_STS: begin
                    st_n[i_nibble] = 1'b1; fin = 1'b1; fin_type = 4'd5;
                end
                D_G0: begin
                    g_base_n = pc; g_lo_n[3:0] = i_nibble; dec_n = D_G1;
                end
                D_G1: begin
                    g_lo_n[7:4] = i_nibble; dec_n = D_G2;
                end
                D_G2: begin
                    pc_n       = target;
                    state_n    = S_LOAD;
                    no_read_n  = 1'b1;
                    load_cnt_n = 3'd0;
                    fin        = 1'b1;
                    fin_type   = 4'd6;
                end
                default: dec_n = D_START;
            endcase

            if (fault) begin
                err_n     = 1'b1;
                state_n   = S_HALT;
                no_read_n = 1'b1;
                dec_n     = D_START;
            end
            if (fin) begin
                decoded_n = 1'b1;
                itype_n   = fin_type;
                dec_n     = D_START;
                if (fin_type != TYPE_LC) begin
                    alu_dest_n = ALU_NONE;
                    alu_src1_n = ALU_NONE;
                    alu_src2_n = ALU_NONE;
                    alu_op_n   = ALU_NONE;
                    alu_imm_n  = 4'hF;
                end
            end
        end
    end

    // State and architectural registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= S_LOAD;
            dec      <= D_START;
            wr_ptr   <= 5'd0;
            load_cnt <= 3'd0;
            pc       <= RESET_PC;
            p        <= 4'd0;
            st       <= 16'd0;
            hst      <= 4'd0;
            c        <= 64'd0;
            err      <= 1'b0;
            no_read  <= 1'b1;
            decoded  <= 1'b0;
            itype    <= 4'd0;
            alu_dest <= 5'd0;
            alu_src1 <= 5'd0;
            alu_src2 <= 5'd0;
            alu_imm  <= 4'd0;
            alu_op   <= 5'd0;
            lc_ptr   <= 4'd0;
            lc_left  <= 4'd0;
            g_base   <= 20'd0;
            g_lo     <= 8'd0;
        end else begin
            state    <= state_n;
            dec      <= dec_n;
            wr_ptr   <= wr_ptr_n;
            load_cnt <= load_cnt_n;
            pc       <= pc_n;
            p        <= p_n;
            st       <= st_n;
            hst      <= hst_n;
            c        <= c_n;
            err      <= err_n;
            no_read  <= no_read_n;
            decoded  <= decoded_n;
            itype    <= itype_n;
            alu_dest <= alu_dest_n;
            alu_src1 <= alu_src1_n;
            alu_src2 <= alu_src2_n;
            alu_imm  <= alu_imm_n;
            alu_op   <= alu_op_n;
            lc_ptr   <= lc_ptr_n;
            lc_left  <= lc_left_n;
            g_base   <= g_base_n;
            g_lo     <= g_lo_n;
        end
    end

    // Program buffer storage; deliberately not cleared by reset
    always_ff @(posedge i_clk) begin
        if (buf_we) prog_buf[wr_ptr] <= buf_wdata;
    end

    // Debugger nibble read of architectural registers
    always_comb begin
        o_dbg_reg_nibble = 4'h0;
        case (i_dbg_register)
            5'd0: begin
                case (i_dbg_reg_ptr)
                    4'd0:    o_dbg_reg_nibble = pc[3:0];
                    4'd1:    o_dbg_reg_nibble = pc[7:4];
                    4'd2:    o_dbg_reg_nibble = pc[11:8];
                    4'd3:    o_dbg_reg_nibble = pc[15:12];
                    4'd4:    o_dbg_reg_nibble = pc[19:16];
                    default: o_dbg_reg_nibble = 4'h0;
                endcase
            end
            5'd1:    o_dbg_reg_nibble = st[{i_dbg_reg_ptr[1:0], 2'b00} +: 4];
            5'd2:    o_dbg_reg_nibble = hst;
            5'd3:    o_dbg_reg_nibble = p;
            5'd4:    o_dbg_reg_nibble = c[{i_dbg_reg_ptr, 2'b00} +: 4];
            default: o_dbg_reg_nibble = 4'h0;
        endcase
    end

    assign o_program_data    = prog_buf[i_program_address];
    assign o_program_address = wr_ptr;
    assign o_no_read         = no_read;
    assign o_error           = err;
    assign o_current_pc      = pc;
    assign o_reg_hst         = hst;
    assign o_reg_st          = st;
    assign o_reg_p           = p;
    assign o_alu_reg_dest    = alu_dest;
    assign o_alu_reg_src_1   = alu_src1;
    assign o_alu_reg_src_2   = alu_src2;
    assign o_alu_imm_value   = alu_imm;
    assign o_alu_opcode      = alu_op;
    assign o_instr_type      = itype;
    assign o_instr_decoded   = decoded;
endmodule

// File: tb/tb_saturn_ctrl_unit.sv
// tb_saturn_ctrl_unit: randomized scoreboard bench for saturn_ctrl_unit.
// Build with SATURN_CTRL_GOTO_EN defined to exercise the relative GOTO.
module tb_saturn_ctrl_unit;
    logic        i_clk = 1'b0;
    logic        i_reset, i_clk_en, i_bus_busy;
    logic [3:0]  i_phases, i_nibble;
    logic [1:0]  i_phase;
    logic [31:0] i_cycle_ctr;
    logic [4:0]  i_program_address;
    logic [4:0]  i_dbg_register = 5'd0;
    logic [3:0]  i_dbg_reg_ptr = 4'd0;
    logic [4:0]  o_program_address, o_program_data;
    logic        o_no_read, o_error, o_instr_decoded;
    logic [19:0] o_current_pc;
    logic [3:0]  o_reg_hst, o_reg_p, o_dbg_reg_nibble, o_alu_imm_value, o_instr_type;
    logic [15:0] o_reg_st;
    logic [4:0]  o_alu_reg_dest, o_alu_reg_src_1, o_alu_reg_src_2, o_alu_opcode;

    saturn_ctrl_unit dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en), .i_phases(i_phases),
        .i_phase(i_phase), .i_cycle_ctr(i_cycle_ctr), .i_bus_busy(i_bus_busy),
        .o_program_address(o_program_address), .i_program_address(i_program_address),
        .o_program_data(o_program_data), .o_no_read(o_no_read), .i_nibble(i_nibble),
        .o_error(o_error), .o_current_pc(o_current_pc), .o_reg_hst(o_reg_hst),
        .o_reg_st(o_reg_st), .o_reg_p(o_reg_p), .i_dbg_register(i_dbg_register),
        .i_dbg_reg_ptr(i_dbg_reg_ptr), .o_dbg_reg_nibble(o_dbg_reg_nibble),
        .o_alu_reg_dest(o_alu_reg_dest), .o_alu_reg_src_1(o_alu_reg_src_1),
        .o_alu_reg_src_2(o_alu_reg_src_2), .o_alu_imm_value(o_alu_imm_value),
        .o_alu_opcode(o_alu_opcode), .o_instr_type(o_instr_type),
        .o_instr_decoded(o_instr_decoded)
    );

    always #10 i_clk = ~i_clk;

    typedef logic [3:0] nib_q_t[$];
    typedef struct packed {
        logic [3:0]  typ;
        logic [19:0] pc;
        logic [3:0]  p;
        logic [15:0] st;
        logic [3:0]  hst;
        logic [63:0] c;
        logic [3:0]  imm;
        logic [3:0]  last_ptr;
        logic [4:0]  alu_dest;
        logic [4:0]  alu_op;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          ph_idx = 0;
    logic [19:0] m_pc;
    logic [3:0]  m_p, m_hst;
    logic [15:0] m_st;
    logic [3:0]  m_c [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // One clock of stimulus; phases advance only on enabled clocks
    task automatic step(input bit en, input bit busy, input logic [3:0] nib);
        i_clk_en   = en;
        i_bus_busy = busy;
        i_nibble   = nib;
        i_phase    = 2'(ph_idx);
        i_phases   = 4'(1 << ph_idx);
        @(posedge i_clk);
        #1;
        i_cycle_ctr = i_cycle_ctr + 32'd1;
        if (en) ph_idx = (ph_idx + 1) % 4;
    endtask

    // Presents nib until one clock where the bus rules allow consumption
    task automatic feed(input logic [3:0] nib);
        bit done;
        done = 1'b0;
        while (!done) begin
            bit en, busy;
            en   = ($urandom_range(0, 7) != 0);
            busy = ($urandom_range(0, 3) == 0);
            if (en && !busy && ph_idx == 2) done = 1'b1;
            step(en, busy, done ? nib : 4'($urandom));
        end
    endtask

    // Instruction-level reference: applies the effect of a whole nibble sequence
    task automatic model_exec(input nib_q_t q, output exp_t e);
        logic [19:0] base;
        logic [11:0] off;
        e = '0;
        e.alu_dest = 5'h1F;
        e.alu_op   = 5'h1F;
        case (q[0])
            4'h2: begin m_p = q[1]; e.typ = 4'd1; end
            4'h3: begin
                for (int i = 0; i <= int'(q[1]); i++) begin
                    m_c[(int'(m_p) + i) % 16] = q[2 + i];
                    e.imm      = q[2 + i];
                    e.last_ptr = 4'((int'(m_p) + i) % 16);
                end
                e.typ = 4'd2; e.alu_dest = 5'd2; e.alu_op = 5'd1;
            end
            4'h0: begin m_st[11:0] = 12'h000; e.typ = 4'd3; end
            4'h8: begin
                if (q[1] == 4'h2) begin m_hst = m_hst & ~q[2]; e.typ = 4'd4; end
                else begin m_st[q[2]] = (q[1] == 4'h5); e.typ = 4'd5; end
            end
            default: e.typ = 4'd6;
        endcase
        if (q[0] == 4'h6) begin
            base = m_pc + 20'd1;
            off  = {q[3], q[2], q[1]};
            m_pc = base + {{8{off[11]}}, off};
        end else begin
            m_pc = m_pc + 20'(q.size());
        end
        e.pc = m_pc; e.p = m_p; e.st = m_st; e.hst = m_hst;
        for (int i = 0; i < 16; i++) e.c[i*4 +: 4] = m_c[i];
    endtask

    task automatic issue(input nib_q_t q);
        exp_t e;
        model_exec(q, e);
        sbq.push_back(e);
        foreach (q[i]) feed(q[i]);
    endtask

    task automatic issue_random();
        nib_q_t q;
        logic [3:0] n;
        n = 4'($urandom);
        case ($urandom_range(0, 5))
            0: q = '{4'h2, n};
            1: begin
                n = 4'($urandom_range(0, 4));
                q = '{4'h3, n};
                for (int i = 0; i <= int'(n); i++) q.push_back(4'($urandom));
            end
            2: q = '{4'h0, 4'h8};
            3: q = '{4'h8, 4'h2, n};
            4: q = '{4'h8, 4'h4, n};
            default: q = '{4'h8, 4'h5, n};
        endcase
        issue(q);
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        i_program_address = 5'd0;
        ph_idx = 0;
        repeat (2) @(posedge i_clk);
        #1;
        m_pc = 20'd0; m_p = 4'd0; m_st = 16'd0; m_hst = 4'd0;
        for (int i = 0; i < 16; i++) m_c[i] = 4'd0;
        chk("rst_wr_ptr", 64'(o_program_address), 64'd0);
        chk("rst_no_read", 64'(o_no_read), 64'd1);
        chk("rst_error", 64'(o_error), 64'd0);
        chk("rst_pc", 64'(o_current_pc), 64'd0);
        chk("rst_p_st_hst", 64'({o_reg_p, o_reg_st, o_reg_hst}), 64'd0);
        chk("rst_decode", 64'({o_instr_decoded, o_instr_type, o_alu_reg_dest, o_alu_opcode}), 64'd0);
        i_reset = 1'b1;
    endtask

    task automatic wait_fetch(input string tag);
        int n;
        n = 0;
        while (o_no_read !== 1'b0 && n < 40) begin
            step(1'b1, 1'b1, 4'h0);
            n++;
        end
        chk({tag, "_no_read_low"}, 64'(o_no_read), 64'd0);
    endtask

    task automatic check_load(input int base, input logic [19:0] pcv, input string tag);
        logic [4:0] ev [7];
        ev[0] = 5'h16;
        for (int i = 0; i < 5; i++) ev[i + 1] = {1'b0, 4'(pcv >> (4 * i))};
        ev[6] = 5'h12;
        for (int i = 0; i < 7; i++) begin
            i_program_address = 5'(base + i);
            #1;
            chk($sformatf("%s_buf%0d", tag, base + i), 64'(o_program_data), 64'(ev[i]));
        end
        chk({tag, "_wr_ptr"}, 64'(o_program_address), 64'(5'(base + 7)));
    endtask

    task automatic error_case(input logic [3:0] nib, input logic [4:0] wp);
        feed(nib);
        m_pc = m_pc + 20'd1;
        repeat (3) step(1'b1, 1'b0, 4'h2);
        chk("err_flag", 64'(o_error), 64'd1);
        chk("err_no_read", 64'(o_no_read), 64'd1);
        chk("err_pc", 64'(o_current_pc), 64'(m_pc));
        repeat (2) feed(4'h2);
        chk("halt_pc_frozen", 64'(o_current_pc), 64'(m_pc));
        chk("halt_wr_ptr_frozen", 64'(o_program_address), 64'(wp));
        chk("halt_error_sticky", 64'(o_error), 64'd1);
    endtask

    // Monitor: pops the expected result whenever an instruction completes
    exp_t mon_e;
    int   mon_ptr;
    always @(negedge i_clk) begin
        if (i_reset === 1'b1 && o_instr_decoded === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_decode: got pulse type %0d required none", o_instr_type);
            end else begin
                mon_e = sbq.pop_front();
                chk("instr_type", 64'(o_instr_type), 64'(mon_e.typ));
                chk("pc", 64'(o_current_pc), 64'(mon_e.pc));
                chk("reg_p", 64'(o_reg_p), 64'(mon_e.p));
                chk("reg_st", 64'(o_reg_st), 64'(mon_e.st));
                chk("reg_hst", 64'(o_reg_hst), 64'(mon_e.hst));
                chk("alu_dest_op", 64'({o_alu_reg_dest, o_alu_opcode}), 64'({mon_e.alu_dest, mon_e.alu_op}));
                chk("alu_srcs", 64'({o_alu_reg_src_1, o_alu_reg_src_2}), 64'(10'h3FF));
                if (mon_e.typ == 4'd2) begin
                    chk("alu_imm", 64'(o_alu_imm_value), 64'(mon_e.imm));
                    i_dbg_register = 5'd4; i_dbg_reg_ptr = mon_e.last_ptr; #1;
                    chk("dbg_c_last", 64'(o_dbg_reg_nibble), 64'(mon_e.c[int'(mon_e.last_ptr)*4 +: 4]));
                end
                mon_ptr = $urandom_range(0, 15);
                i_dbg_register = 5'd4; i_dbg_reg_ptr = 4'(mon_ptr); #1;
                chk("dbg_c", 64'(o_dbg_reg_nibble), 64'(mon_e.c[mon_ptr*4 +: 4]));
                mon_ptr = $urandom_range(0, 7);
                i_dbg_register = 5'd0; i_dbg_reg_ptr = 4'(mon_ptr); #1;
                chk("dbg_pc", 64'(o_dbg_reg_nibble),
                    (mon_ptr <= 4) ? 64'(4'(mon_e.pc >> (4 * mon_ptr))) : 64'd0);
                mon_ptr = $urandom_range(0, 15);
                i_dbg_register = 5'd1; i_dbg_reg_ptr = 4'(mon_ptr); #1;
                chk("dbg_st", 64'(o_dbg_reg_nibble), 64'(mon_e.st[(mon_ptr % 4)*4 +: 4]));
                i_dbg_register = 5'd2; #1;
                chk("dbg_hst", 64'(o_dbg_reg_nibble), 64'(mon_e.hst));
                i_dbg_register = 5'd3; #1;
                chk("dbg_p", 64'(o_dbg_reg_nibble), 64'(mon_e.p));
                i_dbg_register = 5'(5 + $urandom_range(0, 26)); #1;
                chk("dbg_other", 64'(o_dbg_reg_nibble), 64'd0);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b0; i_clk_en = 1'b0; i_bus_busy = 1'b1; i_nibble = 4'h0;
        i_phases = 4'b0001; i_phase = 2'd0; i_cycle_ctr = 32'd0; i_program_address = 5'd0;

        do_reset();
        repeat (3) step(1'b1, 1'b1, 4'h0);
        chk("mid_load_wr_ptr", 64'(o_program_address), 64'd3);
        do_reset();
        wait_fetch("boot");
        check_load(0, 20'h00000, "boot");
        i_program_address = 5'd7;

        issue('{4'h2, 4'h5});
        issue('{4'h3, 4'h1, 4'hA, 4'hB});
        issue('{4'h8, 4'h5, 4'h3});
        issue('{4'h8, 4'h4, 4'h3});
        issue('{4'h8, 4'h2, 4'hF});
        for (int i = 0; i < 40; i++) issue_random();
        repeat (4) step(1'b1, 1'b1, 4'h0);
        chk("sb_drained_1", 64'(sbq.size()), 64'd0);
        error_case(4'hF, 5'd7);

        do_reset();
        wait_fetch("boot2");
        check_load(0, 20'h00000, "boot2");
        i_program_address = 5'd7;
`ifdef SATURN_CTRL_GOTO_EN
        issue('{4'h6, 4'h0, 4'h1, 4'h0});
        wait_fetch("goto");
        check_load(7, 20'h00011, "goto");
        i_program_address = 5'd14;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 4'h2);
        chk("busy_blocks_pc", 64'(o_current_pc), 64'h11);
        for (int i = 0; i < 10; i++) issue_random();
`else
        error_case(4'h6, 5'd7);
`endif
        repeat (4) step(1'b1, 1'b1, 4'h0);
        chk("sb_drained_2", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/saturn_ctrl_unit.md
Name: saturn_ctrl_unit

Overview:
Saturn CPU control unit. Sits between the bus controller and the debugger. It queues bus command/data nibbles into a 32-entry program buffer that the bus controller drains. It fetches and decodes instruction nibbles and owns the PC, P, ST, HST and C registers. It exposes architectural state and decoded-instruction fields to the debugger.

Parameters:
PROG_DEPTH, 32, program buffer entries; pointer width is 5 bits.
RESET_PC, 20'h00000, PC value after reset.

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_clk_en  in  1  clock enable; all state changes are gated by it
i_phases  in  4  one-hot bus phase (0001, 0010, 0100, 1000)
i_phase  in  2  binary phase number, trace only
i_cycle_ctr  in  32  cycle counter, trace only
i_bus_busy  in  1  bus controller still draining the program buffer
o_program_address  out  5  write pointer (next free entry)
i_program_address  in  5  bus controller read pointer
o_program_data  out  5  entry at i_program_address; bit4=1 command, bit4=0 data; [3:0] nibble
o_no_read  out  1  1 = bus must not perform a read
i_nibble  in  4  nibble read from the bus
o_error  out  1  sticky error flag
o_current_pc  out  20  address of the next nibble to fetch
o_reg_hst  out  4  HST register
o_reg_st  out  16  ST register
o_reg_p  out  4  P register
i_dbg_register  in  5  debug register select
i_dbg_reg_ptr  in  4  debug nibble index
o_dbg_reg_nibble  out  4  selected nibble, combinational
o_alu_reg_dest, o_alu_reg_src_1, o_alu_reg_src_2  out  5 each  ALU register codes
o_alu_imm_value  out  4  immediate nibble
o_alu_opcode  out  5  ALU operation
o_instr_type  out  4  decoded instruction class
o_instr_decoded  out  1  one-cycle pulse when an instruction completes

Behaviour:
- Reset (i_reset low, async):
  - PC=RESET_PC; P, ST, HST, C=0.
  - o_error=0; write pointer=0; o_instr_decoded=0; ALU outputs and o_instr_type=0.
  - State=LOAD.
- o_program_data = buffer[i_program_address]. The buffer is combinational-read and is not cleared by reset.
- LOAD state:
  - Writes one entry per enabled clock, in any phase, in this order: {1,6} LOAD_PC; {0,PC[3:0]} ... {0,PC[19:16]} (LSB first); {1,2} PC_READ.
  - The write pointer increments after each write and wraps 31->0.
  - After the 7th write, go to FETCH.
  - o_no_read=1 in LOAD.
- FETCH state:
  - o_no_read=0.
  - A nibble is consumed only when i_phases==0100, i_clk_en=1 and i_bus_busy=0.
  - Each consumed nibble increments PC by 1, modulo 2^20.
- Decode (nibble sequence -> effect; o_instr_type code):
  - 2n: P=n; type 1.
  - 3n d0..dn: load n+1 nibbles into C[P], C[P+1], ... with the pointer mod 16; P is unchanged; type 2.
    - While each nibble loads: ALU dest=2 (C), opcode=1 (COPY), imm=the nibble.
  - 08: ST[11:0]=0; type 3.
  - 82n: HST &= ~n; type 4.
  - 84n: ST[n]=0; 85n: ST[n]=1; type 5.
  - Any other sequence: o_error=1.
- On error:
  - Go to HALT: o_no_read=1, no further fetch or writes.
  - HALT exits only via reset.
- o_instr_decoded pulses for one enabled clock on the final nibble of each instruction.
  - o_instr_type and the ALU fields hold until the next instruction completes.
  - Unused ALU fields are 5'h1F.
- Debug read port (i_dbg_register -> nibble):
  - 0: PC nibble ptr; ptr>4 gives 0.
  - 1: ST nibble ptr[1:0].
  - 2: HST.
  - 3: P.
  - 4: C nibble ptr.
  - Others: 0.
- Writes never overrun the reader: LOAD is entered only when i_program_address==o_program_address.
- Reset mid-LOAD restarts the sequence at pointer 0. The bus controller's pointer resets at the same time.

Optional Feature:
Macro SATURN_CTRL_GOTO_EN.
- Defined: 6 x0 x1 x2 is GOTO, type 6.
  - Target = (address of x0) + signed 12-bit {x2,x1,x0}, modulo 2^20.
  - PC=target, then enter LOAD, which reissues LOAD_PC/target/PC_READ (7 entries), then FETCH.
  - Nibbles arriving between decode and the end of LOAD are discarded.
- Undefined: leading nibble 6 sets o_error.

Test Plan:
1. Reset low, release, i_program_address held equal to the write pointer -> buffer[0..6] = 16,00,00,00,00,00,12 (hex); o_program_address=7; o_no_read=0.
2. Feed 2,5 at phase 0100 with i_bus_busy=0 -> o_reg_p=5; o_instr_decoded pulses once; o_instr_type=1; PC=2.
3. After P=5, feed 3,1,A,B -> C nibble5=A, nibble6=B; debug read (4,6)=B; P remains 5; PC=+4.
4. Feed 8,5,3 then 8,4,3 -> ST=0008 then 0000. Feed 8,2,F -> HST=0.
5. Feed F,F -> o_error=1, o_no_read=1; o_program_address frozen; PC stops.
6. With SATURN_CTRL_GOTO_EN, at PC=0 feed 6,0,1,0 -> PC=00011; 7 new entries 16,01,01,00,00,00,12 (hex); i_bus_busy=1 blocks consumption.
